my_mult_pipe: RTL and testbench
===============================

Name: my_mult_pipe

Overview:
- Pipelined, parametrised fixed-point multiplier for the emulator datapath.
- Generalises the combinational unsigned fixed-point multiply in three ways:
  - selectable signed or unsigned operands
  - round-half-up or truncate on right shift
  - configurable pipeline depth with valid/ready flow control, plus a sticky overflow flag
- Sits between fixed-point producers (filters, CDR/DFE taps) and consumers that may stall.

Parameters:
- a_bits, 8: width of operand a.
- a_point, 4: fractional bits of a.
- b_bits, 8: width of operand b.
- b_point, 4: fractional bits of b.
- c_bits, 8: width of result c.
- c_point, 4: fractional bits of c.
- SIGNED, 0: 1 = two's-complement operands and result, 0 = unsigned.
- ROUND, 0: 1 = round-half-up when right shifting, 0 = truncate (floor).
- STAGES, 2: pipeline register stages, legal range 1..8. Latency equals STAGES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  a_bits  operand a
- b  in  b_bits  operand b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- c  out  c_bits  result
- ovf  out  1  overflow on the result currently presented (qualified by out_valid)
- ovf_sticky  out  1  set on any overflow of a delivered result
- ovf_clr  in  1  clears ovf_sticky

Behaviour:
- Reset is asynchronous, active-high. While rst is high:
  - all stage valid bits, c, ovf and ovf_sticky are 0
  - in_ready is 0
- in_ready rises in the first cycle after rst deasserts.
- Width rules:
  - prod width = a_bits + b_bits. SIGNED=1 uses a signed multiply.
  - rshift = a_point + b_point - c_point.
- rshift > 0:
  - ROUND=1: add 1 << (rshift-1) to prod in one extra guard bit, then shift.
  - ROUND=0: plain shift.
  - The shift is arithmetic when SIGNED=1, logical otherwise.
- rshift = 0: no shift.
- rshift < 0: left shift by -rshift in widened precision.
- Narrowing to c_bits:
  - The default is wrap, keeping the low c_bits.
  - ovf = 1 when the shifted value is not representable in c_bits at the selected signedness.
- The multiply, round and shift are computed combinationally into stage 0. Stages 1..STAGES-1 carry {valid, c, ovf}.
- Handshake:
  - Transfer-in happens when in_valid & in_ready.
  - Transfer-out happens when out_valid & out_ready.
  - Stage k loads from stage k-1 when stage k is empty or stage k advances.
  - in_ready = !stage0_valid | stage0_advances. This is combinational from out_ready through the chain.
  - No bubbles while out_ready = 1: one result per cycle, latency exactly STAGES.
- With out_ready held low, the block holds up to STAGES results. Data and ovf in stalled stages must not change.
- Results leave in order, never duplicated, never dropped.
- Simultaneous in and out transfer on a full pipe is legal and keeps throughput at 1/cycle.
- ovf_sticky is set on a transfer-out with ovf = 1. ovf_clr clears it.
- Simultaneous set and clear: set wins, so the flag reads 1.
- c and ovf are don't-care when out_valid = 0, but must not be X after reset.

Optional Feature:
- Macro: MY_MULT_SAT_EN.
- When defined: out-of-range results clamp instead of wrapping.
  - unsigned: to 2^c_bits - 1
  - signed: to +(2^(c_bits-1) - 1) or -2^(c_bits-1)
  - ovf is still reported.
- When undefined: wrap behaviour as above, with the saturation logic absent.

Decomposition:
- Package my_mult_pkg:
  - function computing rshift
  - localparam helpers for prod width and guard width
  - min/max representable constants for a given width and signedness
- Sub-module my_mult_core: combinational multiply, round, shift and narrow, outputting c and ovf.
- my_mult_pipe instantiates my_mult_core once and wraps it with the valid/ready stage chain.

Test Plan:
- Unsigned basic, default params: a = 0x18, b = 0x20 (1.5 × 2.0) with out_ready = 1. Expect c = 0x30, ovf = 0, exactly 2 cycles after acceptance.
- Signed, SIGNED=1: a = 0xE8 (-1.5), b = 0x20. Expect c = 0xD0. Also a = 0x80, b = 0x80 (-8 × -8 = 64) gives ovf = 1 and c = 0x00 wrapped.
- Rounding: a = 0x01, b = 0x08 (prod 0x08, rshift 4). ROUND=1 gives c = 0x01; ROUND=0 gives c = 0x00. With SIGNED=1, a = 0xFF, b = 0x08: ROUND=0 gives 0xFF, ROUND=1 gives 0x00.
- Overflow, unsigned: a = 0x7F, b = 0x7F gives wrapped c = 0xF0 with ovf = 1 and ovf_sticky = 1. With MY_MULT_SAT_EN defined, c = 0xFF. ovf_clr asserted in the same cycle as a new overflow leaves ovf_sticky = 1.
- Backpressure: stream 20 random pairs with out_ready toggling pseudo-randomly and held low for 10 cycles. Expect:
  - in_ready drops after STAGES items are accepted
  - output sequence matches the reference model in order, with no loss or duplication
  - 1/cycle throughput when out_ready = 1
- Reset mid-operation: assert rst asynchronously with a full pipe. Expect:
  - out_valid, ovf and ovf_sticky go to 0 immediately
  - in_ready goes to 0
  - after release, the first new result appears after STAGES cycles

Source files
------------

// File: rtl/my_mult_pkg.sv
// rtl/my_mult_pkg.sv - shared width helpers and range constants for the fixed-point multiplier
package my_mult_pkg;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 8;

  function automatic int calc_rshift(input int ap, input int bp, input int cp);
    return ap + bp - cp;
  endfunction

  function automatic int prod_width(input int ab, input int bb);
    return ab + bb;
  endfunction

  // Product plus one rounding guard bit plus any left-shift headroom, never narrower than c_bits+1
  function automatic int guard_width(input int ab, input int bb, input int ap, input int bp,
                                     input int cp, input int cb);
    int rs;
    int w;
    rs = calc_rshift(ap, bp, cp);
    w  = prod_width(ab, bb) + 1 + ((rs < 0) ? -rs : 0);
    return (w > cb) ? w : cb + 1;
  endfunction

  function automatic longint max_val(input int bits, input bit sgn);
    return sgn ? ((longint'(1) << (bits - 1)) - 1) : ((longint'(1) << bits) - 1);
  endfunction

  function automatic longint min_val(input int bits, input bit sgn);
    return sgn ? -(longint'(1) << (bits - 1)) : longint'(0);
  endfunction

endpackage

// File: rtl/my_mult_core.sv
// rtl/my_mult_core.sv - combinational multiply, round, shift and narrow to c_bits
// MY_MULT_SAT_EN: clamp out-of-range results instead of wrapping
module my_mult_core
  import my_mult_pkg::*;
#(
  parameter int a_bits  = 8,
  parameter int a_point = 4,
  parameter int b_bits  = 8,
  parameter int b_point = 4,
  parameter int c_bits  = 8,
  parameter int c_point = 4,
  parameter int SIGNED  = 0,
  parameter int ROUND   = 0
) (
  input  logic [a_bits-1:0] a,
  input  logic [b_bits-1:0] b,
  output logic [c_bits-1:0] c,
  output logic              ovf
);

  localparam int RS  = calc_rshift(a_point, b_point, c_point);
  localparam int RSP = (RS > 0) ? RS : 0;
  localparam int LSH = (RS < 0) ? -RS : 0;
  localparam int WW  = guard_width(a_bits, b_bits, a_point, b_point, c_point, c_bits);
  localparam logic [WW-1:0] HALF = (ROUND != 0 && RSP > 0) ?
                                   (WW'(1) << ((RSP > 0) ? RSP - 1 : 0)) : '0;

  logic [WW-1:0] w_a_ext;
  logic [WW-1:0] w_b_ext;
  logic [WW-1:0] w_prod;
  logic [WW-1:0] w_sum;
  logic [WW-1:0] w_shift;
  logic          w_ovf;

  assign w_a_ext = (SIGNED != 0) ? {{(WW-a_bits){a[a_bits-1]}}, a} : {{(WW-a_bits){1'b0}}, a};
  assign w_b_ext = (SIGNED != 0) ? {{(WW-b_bits){b[b_bits-1]}}, b} : {{(WW-b_bits){1'b0}}, b};
  // Extended operands keep the truncated product exact in two's complement
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_sum   = w_prod + HALF;

  generate
    if (SIGNED != 0) begin : g_sgn
      assign w_shift = ($signed(w_sum) >>> RSP) << LSH;
      assign w_ovf   = !((&w_shift[WW-1:c_bits-1]) || !(|w_shift[WW-1:c_bits-1]));
    end else begin : g_uns
      assign w_shift = (w_sum >> RSP) << LSH;
      assign w_ovf   = |w_shift[WW-1:c_bits];
    end
  endgenerate

`ifdef MY_MULT_SAT_EN
  localparam logic [c_bits-1:0] C_MAX = c_bits'(max_val(c_bits, SIGNED != 0));
  localparam logic [c_bits-1:0] C_MIN = c_bits'(min_val(c_bits, SIGNED != 0));

  always_comb begin
    c = w_shift[c_bits-1:0];
    if (w_ovf) begin
      c = (SIGNED != 0 && w_shift[WW-1]) ? C_MIN : C_MAX;
    end
  end
`else
  assign c = w_shift[c_bits-1:0];
`endif

  assign ovf = w_ovf;

endmodule

// File: rtl/my_mult_pipe.sv
// rtl/my_mult_pipe.sv - valid/ready pipelined fixed-point multiplier with sticky overflow
// MY_MULT_SAT_EN: saturating narrowing in the core instead of wrap
module my_mult_pipe
  import my_mult_pkg::*;
#(
  parameter int a_bits  = 8,
  parameter int a_point = 4,
  parameter int b_bits  = 8,
  parameter int b_point = 4,
  parameter int c_bits  = 8,
  parameter int c_point = 4,
  parameter int SIGNED  = 0,
  parameter int ROUND   = 0,
  parameter int STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [a_bits-1:0] a,
  input  logic [b_bits-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [c_bits-1:0] c,
  output logic              ovf,
  output logic              ovf_sticky,
  input  logic              ovf_clr
);

  logic [STAGES-1:0] r_valid;
  logic [c_bits-1:0] r_c [STAGES];
  logic [STAGES-1:0] r_ovf;
  logic              r_ovf_sticky;

  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_adv;
  logic [c_bits-1:0] w_core_c;
  logic              w_core_ovf;

  my_mult_core #(
    .a_bits  (a_bits),
    .a_point (a_point),
    .b_bits  (b_bits),
    .b_point (b_point),
    .c_bits  (c_bits),
    .c_point (c_point),
    .SIGNED  (SIGNED),
    .ROUND   (ROUND)
  ) u_core (
    .a   (a),
    .b   (b),
    .c   (w_core_c),
    .ovf (w_core_ovf)
  );

  // Ready ripples back from the consumer so a full pipe still moves one item per cycle
  always_comb begin
    w_adv  = '0;
    w_load = '0;
    w_adv[STAGES-1]  = r_valid[STAGES-1] & out_ready;
    w_load[STAGES-1] = !r_valid[STAGES-1] | w_adv[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k]  = r_valid[k] & w_load[k+1];
      w_load[k] = !r_valid[k] | w_adv[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_ovf   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_c[k] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_c[0]   <= w_core_c;
          r_ovf[0] <= w_core_ovf;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_c[k]   <= r_c[k-1];
            r_ovf[k] <= r_ovf[k-1];
          end
        end
      end
    end
  end

  // A new overflow leaving the block outranks a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_sticky <= 1'b0;
    end else if (r_valid[STAGES-1] & out_ready & r_ovf[STAGES-1]) begin
      r_ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign in_ready   = w_load[0] & !rst;
  assign out_valid  = r_valid[STAGES-1];
  assign c          = r_c[STAGES-1];
  assign ovf        = r_ovf[STAGES-1];
  assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_my_mult_pipe.sv
// tb/tb_my_mult_pipe.sv - self-checking bench over four signedness/rounding/depth variants
module tb_my_mult_pipe;

  localparam int N = 4;
  localparam int STG [N] = '{2, 3, 2, 1};
  localparam int SGA [N] = '{0, 1, 1, 0};
  localparam int RDA [N] = '{0, 1, 0, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  wire [N-1:0]      ir;
  wire [N-1:0]      ov;
  wire [N-1:0]      of;
  wire [N-1:0]      st;
  wire [N-1:0][7:0] cc;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [8:0] sb [N][64];
  int         wp [N];
  int         rp [N];
  int         base [N];

  int         lat [N];
  logic [7:0] got_c [N];
  logic       got_o [N];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c [N];
    logic       o [N];
    logic       sneg;
  } vec_t;

  vec_t vecs [$];

  for (genvar g = 0; g < N; g++) begin : g_dut
    my_mult_pipe #(
      .a_bits(8), .a_point(4), .b_bits(8), .b_point(4), .c_bits(8), .c_point(4),
      .SIGNED(SGA[g]), .ROUND(RDA[g]), .STAGES(STG[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (ir[g]),
      .a          (a),
      .b          (b),
      .out_valid  (ov[g]),
      .out_ready  (out_ready),
      .c          (cc[g]),
      .ovf        (of[g]),
      .ovf_sticky (st[g]),
      .ovf_clr    (ovf_clr)
    );
  end

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Q4.4 x Q4.4 -> Q4.4 by real-number arithmetic: value = floor((prod [+8]) / 16)
  function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input bit sg, input bit rd);
    longint pa, pb, p, v, lo, hi, m;
    logic   o;
    if (sg) begin
      pa = longint'($signed(av));
      pb = longint'($signed(bv));
      lo = -128;
      hi = 127;
    end else begin
      pa = longint'({56'd0, av});
      pb = longint'({56'd0, bv});
      lo = 0;
      hi = 255;
    end
    p = pa * pb;
    if (rd) p = p + 8;
    v = p / 16;
    if ((p % 16 != 0) && (p < 0)) v = v - 1;
    o = (v < lo) || (v > hi);
    m = v % 256;
    if (m < 0) m = m + 256;
`ifdef MY_MULT_SAT_EN
    if (v > hi) m = hi;
    else if (v < lo) m = lo + 256;
`endif
    return {o, m[7:0]};
  endfunction

  function automatic logic [7:0] exp_c(input logic [7:0] cw, input logic o, input bit sg,
                                       input logic sneg);
`ifdef MY_MULT_SAT_EN
    if (o) return sg ? (sneg ? 8'h80 : 8'h7F) : 8'hFF;
`endif
    return cw;
  endfunction

  task automatic add_vec(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] c0, input logic o0, input logic [7:0] c1, input logic o1,
                         input logic [7:0] c2, input logic o2, input logic [7:0] c3, input logic o3,
                         input logic sneg);
    vec_t v;
    v.a = av; v.b = bv; v.sneg = sneg;
    v.c[0] = c0; v.o[0] = o0; v.c[1] = c1; v.o[1] = o1;
    v.c[2] = c2; v.o[2] = o2; v.c[3] = c3; v.o[3] = o3;
    vecs.push_back(v);
  endtask

  // One isolated transaction; records first out_valid negedge count per instance
  task automatic send_vec(input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < N; i++) begin
      lat[i] = -1; got_c[i] = 8'h00; got_o[i] = 1'b0;
    end
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ov[i] && lat[i] < 0) begin
          lat[i] = n; got_c[i] = cc[i]; got_o[i] = of[i];
        end
      end
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < N; i++) begin
        if (ov[i] && out_ready) begin
          if (rp[i] == wp[i]) begin
            chk($sformatf("sb_extra_i%0d", i), 32'd1, 32'd0);
          end else begin
            chk($sformatf("sb_item%0d_i%0d", rp[i], i), {23'd0, of[i], cc[i]}, {23'd0, sb[i][rp[i] % 64]});
            rp[i]++;
          end
        end
        if (in_valid && ir[i]) begin
          sb[i][wp[i] % 64] = model(a, b, SGA[i] != 0, RDA[i] != 0);
          wp[i]++;
        end
      end
    end
  end

  initial begin
    int last0;
    int cyc;
    for (int i = 0; i < N; i++) begin
      wp[i] = 0; rp[i] = 0; base[i] = 0;
    end
    //       a      b      U/T:c,o   S/R:c,o   S/T:c,o   U/R:c,o   sneg
    add_vec(8'h18, 8'h20, 8'h30, 0, 8'h30, 0, 8'h30, 0, 8'h30, 0, 0);
    add_vec(8'hE8, 8'h20, 8'hD0, 1, 8'hD0, 0, 8'hD0, 0, 8'hD0, 1, 0);
    add_vec(8'h80, 8'h80, 8'h00, 1, 8'h00, 1, 8'h00, 1, 8'h00, 1, 0);
    add_vec(8'h01, 8'h08, 8'h00, 0, 8'h01, 0, 8'h00, 0, 8'h01, 0, 0);
    add_vec(8'hFF, 8'h08, 8'h7F, 0, 8'h00, 0, 8'hFF, 0, 8'h80, 0, 0);
    add_vec(8'h7F, 8'h7F, 8'hF0, 1, 8'hF0, 1, 8'hF0, 1, 8'hF0, 1, 0);
    add_vec(8'h00, 8'hFF, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);
    add_vec(8'hFF, 8'hFF, 8'hE0, 1, 8'h00, 0, 8'h00, 0, 8'hE0, 1, 0);
    add_vec(8'h10, 8'hF0, 8'hF0, 0, 8'hF0, 0, 8'hF0, 0, 8'hF0, 0, 0);
    add_vec(8'hF8, 8'h10, 8'hF8, 0, 8'hF8, 0, 8'hF8, 0, 8'hF8, 0, 0);
    add_vec(8'h80, 8'h10, 8'h80, 0, 8'h80, 0, 8'h80, 0, 8'h80, 0, 0);
    add_vec(8'h80, 8'h11, 8'h88, 0, 8'h78, 1, 8'h78, 1, 8'h88, 0, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_out_valid_i%0d", i), ov[i], 1'b0);
      chk($sformatf("rst_in_ready_i%0d", i), ir[i], 1'b0);
      chk($sformatf("rst_ovf_i%0d", i), of[i], 1'b0);
      chk($sformatf("rst_sticky_i%0d", i), st[i], 1'b0);
      chk($sformatf("rst_c_i%0d", i), cc[i], 8'h00);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) chk($sformatf("post_rst_in_ready_i%0d", i), ir[i], 1'b1);
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      send_vec(vecs[v].a, vecs[v].b);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("v%0d_lat_i%0d", v, i), lat[i], STG[i]);
        chk($sformatf("v%0d_c_i%0d", v, i), got_c[i],
            exp_c(vecs[v].c[i], vecs[v].o[i], SGA[i] != 0, vecs[v].sneg));
        chk($sformatf("v%0d_ovf_i%0d", v, i), got_o[i], vecs[v].o[i]);
        if (v == 0) chk($sformatf("v0_sticky_i%0d", i), st[i], 1'b0);
      end
    end
    for (int i = 0; i < N; i++) chk($sformatf("sticky_set_i%0d", i), st[i], 1'b1);

    ovf_clr = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) chk($sformatf("sticky_clr_i%0d", i), st[i], 1'b0);
    a = 8'h7F; b = 8'h7F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("setclr_out_valid_i0", ov[0], 1'b1);
    chk("setclr_ovf_i0", of[0], 1'b1);
    @(posedge clk); #1;
    chk("setclr_wins_i0", st[0], 1'b1);
    chk("setclr_wins_i2", st[2], 1'b1);
    @(posedge clk); #1;
    chk("setclr_then_clr_i0", st[0], 1'b0);
    ovf_clr = 1'b0;
    repeat (4) @(posedge clk); #1;

    mon_en = 1'b1;
    for (int i = 0; i < N; i++) base[i] = wp[i];
    out_ready = 1'b0; in_valid = 1'b1;
    a = 8'($urandom); b = 8'($urandom);
    last0 = wp[0];
    repeat (10) begin
      @(posedge clk); #1;
      if (wp[0] != last0) begin
        last0 = wp[0]; a = 8'($urandom); b = 8'($urandom);
      end
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("stall_accepts_i%0d", i), wp[i] - base[i], STG[i]);
      chk($sformatf("stall_in_ready_i%0d", i), ir[i], 1'b0);
    end
    cyc = 0;
    while ((wp[0] - base[0] < 22) && (cyc < 400)) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
      if (wp[0] != last0) begin
        last0 = wp[0]; a = 8'($urandom); b = 8'($urandom);
      end
    end
    chk("stream_budget", (wp[0] - base[0] >= 22), 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    for (int i = 0; i < N; i++) chk($sformatf("stream_drained_i%0d", i), rp[i], wp[i]);

    in_valid = 1'b1;
    a = 8'($urandom); b = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("tput_k%0d_out_valid_i%0d", k, i), ov[i], (k >= STG[i]));
        chk($sformatf("tput_k%0d_in_ready_i%0d", k, i), ir[i], 1'b1);
      end
      @(posedge clk); #1;
      a = 8'($urandom); b = 8'($urandom);
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    for (int i = 0; i < N; i++) chk($sformatf("tput_drained_i%0d", i), rp[i], wp[i]);
    mon_en = 1'b0;

    a = 8'h7F; b = 8'h7F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < N; i++) chk($sformatf("pre_rst_sticky_i%0d", i), st[i], 1'b1);
    out_ready = 1'b0; in_valid = 1'b1;
    a = 8'h7F; b = 8'h7F;
    repeat (5) @(posedge clk); #1;
    for (int i = 0; i < N; i++) chk($sformatf("full_out_valid_i%0d", i), ov[i], 1'b1);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("async_rst_out_valid_i%0d", i), ov[i], 1'b0);
      chk($sformatf("async_rst_ovf_i%0d", i), of[i], 1'b0);
      chk($sformatf("async_rst_sticky_i%0d", i), st[i], 1'b0);
      chk($sformatf("async_rst_in_ready_i%0d", i), ir[i], 1'b0);
    end
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("rerelease_in_ready_i%0d", i), ir[i], 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_vec(8'h18, 8'h20);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("after_rst_lat_i%0d", i), lat[i], STG[i]);
      chk($sformatf("after_rst_c_i%0d", i), got_c[i], 8'h30);
      chk($sformatf("after_rst_sticky_i%0d", i), st[i], 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
